// File: rtl/text_buffer.sv
`default_nettype none
// ============================================================================
// Module   : text_buffer
// Purpose  : Cursor-edited COLS x ROWS ASCII screen store that feeds the VGA
//            text renderer. It takes a byte stream and serves the code for the
//            cell under pixel (x, y) with a one-cycle registered latency.
// Options  : CURSOR_BLINK_EN - when defined, a blinking '_' cursor is
//            overlaid on the cell at cursor_idx while the buffer is not full.
// Revision : 1.0 - initial release
// ============================================================================
module text_buffer #(
  parameter int COLS       = 32,
  parameter int ROWS       = 4,
  parameter int X0         = 192,
  parameter int Y0         = 208,
  parameter int BLINK_BITS = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [7:0] ascii_code,
  output logic [7:0] cursor_idx,
  output logic       full
);

  localparam int         CELLS   = COLS * ROWS;
  localparam int         AW      = $clog2(CELLS);
  localparam int         CB      = $clog2(COLS);
  localparam int         RB      = $clog2(ROWS);
  localparam logic [7:0] CELLS_C = 8'(CELLS);
  localparam logic [7:0] SPACE   = 8'h20;
  localparam logic [7:0] CH_BS   = 8'h08;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_FF   = 8'h0C;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic [7:0]      cursor_q, cursor_d;
  logic [7:0]      ascii_code_q, ascii_code_d;

  logic [7:0]      mem [CELLS];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [7:0]      mem_wdata;

  logic            full_w;
  logic [7:0]      bs_idx;
  logic [8:0]      cr_next;
  logic [9:0]      x_off, y_off;
  logic            in_win;
  logic [AW-1:0]   rd_addr;
  logic            show_cursor;
  logic            unused_bits;

  assign full_w     = (cursor_q == CELLS_C);
  assign full       = full_w;
  assign cursor_idx = cursor_q;
  assign ascii_code = ascii_code_q;

  // Backspace target and next-row start (OR-ing in the column bits then
  // adding one lands on the first column of the following row).
  assign bs_idx  = cursor_q - 8'd1;
  assign cr_next = {1'b0, cursor_q | 8'(COLS - 1)} + 9'd1;

  // Editing FSM: owns the write port, either clearing or applying input bytes.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    cursor_d   = cursor_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_addr_q;
    mem_wdata  = SPACE;
    wr_ready   = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_we     = 1'b1;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == AW'(CELLS - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          if (wr_data >= 8'h20 && wr_data <= 8'h7E) begin
            // Once full, printable bytes are accepted but discarded.
            if (!full_w) begin
              mem_we    = 1'b1;
              mem_waddr = cursor_q[AW-1:0];
              mem_wdata = wr_data;
              cursor_d  = cursor_q + 8'd1;
            end
          end else if (wr_data == CH_BS) begin
            if (cursor_q != 8'd0) begin
              mem_we    = 1'b1;
              mem_waddr = bs_idx[AW-1:0];
              mem_wdata = SPACE;
              cursor_d  = bs_idx;
            end
          end else if (wr_data == CH_CR) begin
            cursor_d = (cr_next > 9'(CELLS)) ? CELLS_C : cr_next[7:0];
          end else if (wr_data == CH_FF) begin
            cursor_d   = 8'd0;
            clr_addr_d = '0;
            state_d    = CLEAR;
          end
        end
      end
      default: begin
        state_d    = CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  // Control state register; reset restarts the screen clear from cell 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      clr_addr_q   <= '0;
      cursor_q     <= 8'd0;
      ascii_code_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      cursor_q     <= cursor_d;
      ascii_code_q <= ascii_code_d;
    end
  end

  // Character RAM write port; the registered read below sees the old value
  // when both ports hit the same cell in one cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Window test is done on the raw coordinates so the wrapped offsets of
  // out-of-window pixels never select a cell.
  assign x_off   = x - 10'(X0);
  assign y_off   = y - 10'(Y0);
  assign in_win  = (x >= 10'(X0)) && (x < 10'(X0 + 8 * COLS)) &&
                   (y >= 10'(Y0)) && (y < 10'(Y0 + 16 * ROWS));
  assign rd_addr = {y_off[4 +: RB], x_off[3 +: CB]};

  // Pixel offset bits below the cell size and above the window are not used.
  assign unused_bits = ^{x_off[2:0], x_off[9:3+CB], y_off[3:0], y_off[9:4+RB]};

`ifdef CURSOR_BLINK_EN
  logic [BLINK_BITS-1:0] blink_q, blink_d;

  assign blink_d = blink_q + 1'b1;

  // Free-running blink timer; the cursor is drawn while its MSB is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign show_cursor = blink_q[BLINK_BITS-1] && !full_w &&
                       (8'(rd_addr) == cursor_q);
`else
  logic unused_blink;
  assign unused_blink = (BLINK_BITS > 0);
  assign show_cursor  = 1'b0;
`endif

  // Read-port mux: RAM data (or cursor glyph) inside the window, NUL outside.
  always_comb begin
    ascii_code_d = 8'h00;
    if (in_win) begin
      ascii_code_d = show_cursor ? 8'h5F : mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_text_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_buffer
// Purpose  : Directed self-checking bench for text_buffer. Define
//            CURSOR_BLINK_EN to exercise the blinking cursor overlay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_buffer;

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [9:0] x;
  logic [9:0] y;
  logic [7:0] ascii_code;
  logic [7:0] cursor_idx;
  logic       full;

  int passed;
  int total;
  int m_cursor;

  text_buffer #(
    .COLS(32), .ROWS(4), .X0(192), .Y0(208), .BLINK_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .x(x), .y(y), .ascii_code(ascii_code),
    .cursor_idx(cursor_idx), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (wr_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (wr_ready !== 1'b1) begin
      total++;
      $display("FAIL wait_ready: wr_ready=%b required 1 within 300 cycles", wr_ready);
    end
  endtask

  // Offers one byte and tracks the expected cursor for the overlay handling.
  task automatic send_byte(input logic [7:0] d);
    wait_ready();
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    if (d >= 8'h20 && d <= 8'h7E) begin
      if (m_cursor < 128) m_cursor++;
    end else if (d == 8'h08) begin
      if (m_cursor > 0) m_cursor--;
    end else if (d == 8'h0D) begin
      m_cursor = ((m_cursor / 32) + 1) * 32;
      if (m_cursor > 128) m_cursor = 128;
    end else if (d == 8'h0C) begin
      m_cursor = 0;
    end
  endtask

  // Reads a cell through the pixel port; with the overlay built in, waits
  // out the cursor-visible phase so the RAM contents are returned.
  task automatic read_cell(input int idx, output logic [7:0] v);
    x = 10'(192 + 8 * (idx % 32) + 3);
    y = 10'(208 + 16 * (idx / 32) + 7);
    tick();
    v = ascii_code;
`ifdef CURSOR_BLINK_EN
    for (int k = 0; k < 16; k++) begin
      if (v == 8'h5F && idx == m_cursor) begin
        tick();
        v = ascii_code;
      end
    end
`endif
  endtask

  // Counts consecutive samples with wr_ready low, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (wr_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int         n;
    logic [7:0] v;
    int         bad;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    x = 10'd0;
    y = 10'd0;
    m_cursor = 0;
    tick();
    reset    = 1'b0;
    wr_valid = 1'b1;
    total++;
    if (wr_ready !== 1'b0 || cursor_idx !== 8'd0 || full !== 1'b0 || ascii_code !== 8'h00) begin
      $display("FAIL reset_state: ready=%b cursor=%0d full=%b ascii=%h required 0 0 0 00",
               wr_ready, cursor_idx, full, ascii_code);
    end else passed++;
    count_busy(n);
    wr_valid = 1'b0;
    total++;
    if (n !== 128) $display("FAIL clear_cycles: busy=%0d required 128", n);
    else passed++;
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      read_cell(i, v);
      if (v !== 8'h20) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL cleared_cells: %0d cells not 20, required 0", bad);
    else passed++;
    total++;
    if (cursor_idx !== 8'd0) $display("FAIL reset_cursor: cursor=%0d required 0", cursor_idx);
    else passed++;
  endtask

  task automatic test_write_hi();
    logic [7:0] v;
    send_byte(8'h48);
    send_byte(8'h49);
    read_cell(0, v);
    total++;
    if (v !== 8'h48) $display("FAIL hi_cell0: got %h required 48", v);
    else passed++;
    read_cell(1, v);
    total++;
    if (v !== 8'h49) $display("FAIL hi_cell1: got %h required 49", v);
    else passed++;
    total++;
    if (cursor_idx !== 8'd2) $display("FAIL hi_cursor: got %0d required 2", cursor_idx);
    else passed++;
    x = 10'd200;
    y = 10'd208;
    tick();
    total++;
    if (ascii_code !== 8'h49) $display("FAIL hi_pixel: got %h required 49", ascii_code);
    else passed++;
  endtask

  task automatic test_wrap_and_cr();
    logic [7:0] v;
    send_byte(8'h0C);
    for (int i = 0; i < 33; i++) send_byte(8'h41);
    read_cell(32, v);
    total++;
    if (v !== 8'h41) $display("FAIL wrap_cell32: got %h required 41", v);
    else passed++;
    read_cell(33, v);
    total++;
    if (v !== 8'h20) $display("FAIL wrap_cell33: got %h required 20", v);
    else passed++;
    total++;
    if (cursor_idx !== 8'd33) $display("FAIL wrap_cursor: got %0d required 33", cursor_idx);
    else passed++;
    send_byte(8'h0D);
    total++;
    if (cursor_idx !== 8'd64) $display("FAIL cr_cursor64: got %0d required 64", cursor_idx);
    else passed++;
    send_byte(8'h0D);
    total++;
    if (cursor_idx !== 8'd96 || full !== 1'b0)
      $display("FAIL cr_cursor96: got %0d full=%b required 96 full=0", cursor_idx, full);
    else passed++;
    send_byte(8'h0D);
    send_byte(8'h0D);
    total++;
    if (cursor_idx !== 8'd128 || full !== 1'b1)
      $display("FAIL cr_saturate: got %0d full=%b required 128 full=1", cursor_idx, full);
    else passed++;
    send_byte(8'h5A);
    total++;
    if (cursor_idx !== 8'd128 || full !== 1'b1)
      $display("FAIL full_drop_cursor: got %0d full=%b required 128 full=1", cursor_idx, full);
    else passed++;
    read_cell(127, v);
    total++;
    if (v !== 8'h20) $display("FAIL full_drop_cell127: got %h required 20", v);
    else passed++;
    read_cell(0, v);
    total++;
    if (v !== 8'h41) $display("FAIL full_drop_cell0: got %h required 41", v);
    else passed++;
  endtask

  task automatic test_backspace();
    logic [7:0] v;
    send_byte(8'h08);
    total++;
    if (cursor_idx !== 8'd127 || full !== 1'b0)
      $display("FAIL bs_from_full: got %0d full=%b required 127 full=0", cursor_idx, full);
    else passed++;
    send_byte(8'h51);
    total++;
    if (cursor_idx !== 8'd128 || full !== 1'b1)
      $display("FAIL last_cell_full: got %0d full=%b required 128 full=1", cursor_idx, full);
    else passed++;
    read_cell(127, v);
    total++;
    if (v !== 8'h51) $display("FAIL last_cell_data: got %h required 51", v);
    else passed++;
    send_byte(8'h08);
    read_cell(127, v);
    total++;
    if (v !== 8'h20 || cursor_idx !== 8'd127 || full !== 1'b0)
      $display("FAIL bs_erase: cell=%h cursor=%0d full=%b required 20 127 0", v, cursor_idx, full);
    else passed++;
    send_byte(8'h0C);
    send_byte(8'h42);
    send_byte(8'h43);
    send_byte(8'h08);
    read_cell(1, v);
    total++;
    if (v !== 8'h20 || cursor_idx !== 8'd1)
      $display("FAIL bs_mid: cell1=%h cursor=%0d required 20 1", v, cursor_idx);
    else passed++;
    read_cell(0, v);
    total++;
    if (v !== 8'h42) $display("FAIL bs_keep: cell0=%h required 42", v);
    else passed++;
    send_byte(8'h08);
    send_byte(8'h08);
    read_cell(0, v);
    total++;
    if (cursor_idx !== 8'd0 || v !== 8'h20)
      $display("FAIL bs_at_zero: cursor=%0d cell0=%h required 0 20", cursor_idx, v);
    else passed++;
    send_byte(8'h01);
    total++;
    if (cursor_idx !== 8'd0 || wr_ready !== 1'b1)
      $display("FAIL ignored_byte: cursor=%0d ready=%b required 0 1", cursor_idx, wr_ready);
    else passed++;
  endtask

  task automatic test_window();
    logic [7:0] v;
    send_byte(8'h0D);
    send_byte(8'h0D);
    send_byte(8'h0D);
    send_byte(8'h52);
    x = 10'd191; y = 10'd208; tick();
    total++;
    if (ascii_code !== 8'h00) $display("FAIL win_left: got %h required 00", ascii_code);
    else passed++;
    x = 10'd448; y = 10'd208; tick();
    total++;
    if (ascii_code !== 8'h00) $display("FAIL win_right: got %h required 00", ascii_code);
    else passed++;
    x = 10'd300; y = 10'd272; tick();
    total++;
    if (ascii_code !== 8'h00) $display("FAIL win_bottom: got %h required 00", ascii_code);
    else passed++;
    x = 10'd300; y = 10'd207; tick();
    total++;
    if (ascii_code !== 8'h00) $display("FAIL win_top: got %h required 00", ascii_code);
    else passed++;
    x = 10'd192; y = 10'd271; tick();
    total++;
    if (ascii_code !== 8'h52) $display("FAIL win_cell96: got %h required 52", ascii_code);
    else passed++;
    read_cell(127, v);
    total++;
    if (v !== 8'h20) $display("FAIL win_cell127: got %h required 20", v);
    else passed++;
  endtask

  task automatic test_reset_mid_clear();
    int n;
    send_byte(8'h0C);
    repeat (50) tick();
    total++;
    if (wr_ready !== 1'b0) $display("FAIL mid_clear_busy: ready=%b required 0", wr_ready);
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_cursor = 0;
    count_busy(n);
    total++;
    if (n !== 128) $display("FAIL restart_cycles: busy=%0d required 128", n);
    else passed++;
  endtask

  task automatic test_cursor_blink();
    logic [7:0] s [24];
    int         bad;
    for (int i = 0; i < 5; i++) send_byte(8'h61);
    total++;
    if (cursor_idx !== 8'd5) $display("FAIL blink_cursor: got %0d required 5", cursor_idx);
    else passed++;
    x = 10'd232;
    y = 10'd210;
    tick();
    for (int i = 0; i < 24; i++) begin
      tick();
      s[i] = ascii_code;
    end
    bad = 0;
`ifdef CURSOR_BLINK_EN
    for (int i = 0; i < 24; i++) begin
      if (s[i] !== 8'h20 && s[i] !== 8'h5F) bad++;
      if (i >= 8 && s[i] === s[i-8]) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL blink_pattern: %0d bad samples, required 0", bad);
    else passed++;
`else
    for (int i = 0; i < 24; i++) begin
      if (s[i] !== 8'h20) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL no_blink: %0d samples not 20, required 0", bad);
    else passed++;
`endif
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    m_cursor = 0;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    x        = 10'd0;
    y        = 10'd0;
    test_reset();
    test_write_hi();
    test_wrap_and_cr();
    test_backspace();
    test_window();
    test_reset_mid_clear();
    test_cursor_blink();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
